prga: RTL and testbench
=======================

// Module: prga
// PURPOSE
//  RC4 pseudo-random generation stage: reads the key-scheduled S array left by the
//  key-scheduling block, swaps S entries per byte and XORs keystream with ciphertext.
//  Ciphertext memory is length-prefixed: ct[0] = L, ct[1..L] = message bytes.
//  Writes the plaintext with the same layout: pt[0] = L, pt[1..L] = plaintext.
//  Sits after key scheduling inside the cracker datapath; same en/rdy handshake.
// PARAMETERS
//  none (8-bit S/ct/pt memories, 256 entries each, fixed by RC4)
// PORTS
//  clk         in   1  system clock; all state changes on rising edge
//  rst         in   1  reset, synchronous, active-high
//  en          in   1  start request; honoured only while rdy=1
//  rdy         out  1  1 = idle and able to accept en
//  s_addr      out  8  S memory address
//  s_rddata    in   8  S read data, valid the cycle after s_addr presented with s_wren=0
//  s_wrdata    out  8  S write data
//  s_wren      out  1  S write enable
//  ct_addr     out  8  ciphertext memory address (read-only)
//  ct_rddata   in   8  ciphertext read data, 1-cycle latency as for S
//  pt_addr     out  8  plaintext memory address
//  pt_wrdata   out  8  plaintext write data
//  pt_wren     out  1  plaintext write enable
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, i=j=k=0, len=0; outputs after reset:
//   rdy=1, s_wren=0, pt_wren=0, all addr/wrdata=0. Mid-run reset aborts; no further writes.
//  rdy = (state==IDLE), decoded combinationally from state. en in any other state is ignored.
//  Memory outputs decoded from state (Moore); both wren are 0 in every state not listed.
//  States and per-cycle actions:
//   IDLE    : i=j=0; en=1 -> RD_LEN
//   RD_LEN  : ct_addr=0 -> GET_LEN
//   GET_LEN : len=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1; k=1;
//             len==0 -> DONE, else -> REQ_SI with i=1
//   REQ_SI  : s_addr=i -> GET_SI
//   GET_SI  : si=s_rddata; j=(j+s_rddata) mod 256 -> REQ_SJ
//   REQ_SJ  : s_addr=j -> GET_SJ
//   GET_SJ  : sj=s_rddata -> WR_SI
//   WR_SI   : s_addr=j, s_wrdata=si, s_wren=1 -> WR_SJ
//   WR_SJ   : s_addr=i, s_wrdata=sj, s_wren=1 -> REQ_PAD
//   REQ_PAD : s_addr=(si+sj) mod 256; ct_addr=k (parallel reads) -> WR_PT
//   WR_PT   : pt_addr=k, pt_wrdata=s_rddata^ct_rddata, pt_wren=1;
//             k==len -> DONE, else k=k+1, i=i+1 -> REQ_SI
//   DONE    : no memory activity -> IDLE
//  Width rules: all index/sum arithmetic 8-bit, wraps mod 256; i,k run 1..len (len<=255),
//   so i never wraps; j and pad index wrap freely.
//  i==j: WR_SI and WR_SJ hit the same address with equal data; S unchanged. Required.
//  Pad index uses pre-swap si,sj (sum equals post-swap S[i]+S[j]).
//  Latency: en accepted at edge E -> rdy=1 again exactly 4+8L cycles after E.
//  Back-to-back: en held high in IDLE starts a new run immediately; S is not restored.
// TESTING
//  S identity, ct={1,0x00} -> pt[0]=1, pt[1]=0x02; S unchanged; rdy back after 12 cycles
//  S identity, ct={2,0x00,0xFF} -> pt={2,0x02,0xFA}; S[2]=3, S[3]=2, others identity
//  ct[0]=0 -> pt[0]=0 written once, no s_wren ever, rdy=1 four cycles after en
//  S[1]=0xFF else identity, ct={1,0x00} -> j=0xFF, S[1]<->S[0xFF] swap; pad=S[0xFE]=0xFE
//  en pulsed mid-run -> ignored; rst mid-run -> next cycle rdy=1, no further wren
//  S = random KSA output, L=255 vs software RC4 model -> all 256 pt bytes match

Source files
------------

// File: rtl/prga.sv
// RC4 pseudo-random generation stage: swaps S entries per message byte and
// XORs the keystream with the length-prefixed ciphertext into plaintext memory.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   en / rdy             start request, accepted only while rdy (idle)
//   s_addr/s_rddata/
//   s_wrdata/s_wren      S array (1-cycle read latency)
//   ct_addr/ct_rddata    ciphertext memory, ct[0]=L, ct[1..L]=data
//   pt_addr/pt_wrdata/
//   pt_wren              plaintext memory, pt[0]=L, pt[1..L]=data
module prga (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE, RD_LEN, GET_LEN, REQ_SI, GET_SI, REQ_SJ,
        GET_SJ, WR_SI, WR_SJ, REQ_PAD, WR_PT, DONE
    } state_t;

    state_t     state, state_n;
    logic [7:0] i, i_n;
    logic [7:0] j, j_n;
    logic [7:0] k, k_n;
    logic [7:0] len, len_n;
    logic [7:0] si, si_n;
    logic [7:0] sj, sj_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            len   <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            k     <= k_n;
            len   <= len_n;
            si    <= si_n;
            sj    <= sj_n;
        end
    end

    assign rdy = (state == IDLE);

    always_comb begin
        state_n   = state;
        i_n       = i;
        j_n       = j;
        k_n       = k;
        len_n     = len;
        si_n      = si;
        sj_n      = sj;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;

        unique case (state)
            IDLE: begin
                i_n = 8'd0;
                j_n = 8'd0;
                if (en) state_n = RD_LEN;
            end
            RD_LEN: begin
                ct_addr = 8'd0;
                state_n = GET_LEN;
            end
            GET_LEN: begin
                len_n     = ct_rddata;
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                k_n       = 8'd1;
                if (ct_rddata == 8'd0) begin
                    state_n = DONE;
                end else begin
                    i_n     = 8'd1;
                    state_n = REQ_SI;
                end
            end
            REQ_SI: begin
                s_addr  = i;
                state_n = GET_SI;
            end
            GET_SI: begin
                si_n    = s_rddata;
                j_n     = j + s_rddata;
                state_n = REQ_SJ;
            end
            REQ_SJ: begin
                s_addr  = j;
                state_n = GET_SJ;
            end
            GET_SJ: begin
                sj_n    = s_rddata;
                state_n = WR_SI;
            end
            WR_SI: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_n  = WR_SJ;
            end
            WR_SJ: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
                state_n  = REQ_PAD;
            end
            REQ_PAD: begin
                // pre-swap si+sj equals post-swap S[i]+S[j]
                s_addr  = si + sj;
                ct_addr = k;
                state_n = WR_PT;
            end
            WR_PT: begin
                pt_addr   = k;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                if (k == len) begin
                    state_n = DONE;
                end else begin
                    k_n     = k + 8'd1;
                    i_n     = i + 8'd1;
                    state_n = REQ_SI;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Testbench for prga: table of short messages with hand-computed plaintext,
// plus en-pulse, mid-run reset and a full 255-byte run against a software RC4.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    always #5 clk = ~clk;

    prga dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    logic [7:0] smem  [256];
    logic [7:0] sinit [256];
    logic [7:0] ctmem [256];
    logic [7:0] ptmem [256];
    logic       load = 1'b0;
    int         s_wr_cnt;
    int         pt_wr_cnt;

    // memory models: 1-cycle read latency; load preloads S, poisons pt
    always @(posedge clk) begin
        if (load) begin
            smem <= sinit;
            for (int a = 0; a < 256; a++) ptmem[a] <= 8'hEE;
            s_wr_cnt  <= 0;
            pt_wr_cnt <= 0;
        end else begin
            if (s_wren) begin
                smem[s_addr] <= s_wrdata;
                s_wr_cnt     <= s_wr_cnt + 1;
            end
            if (pt_wren) begin
                ptmem[pt_addr] <= pt_wrdata;
                pt_wr_cnt      <= pt_wr_cnt + 1;
            end
        end
        s_rddata  <= smem[s_addr];
        ct_rddata <= ctmem[ct_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // called at a negedge; counts edges from the en cycle until rdy is seen
    task automatic run_job(input int pulse_at, output int cyc);
        cyc = 0;
        en  = 1'b1;
        while (cyc < 5000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (rdy) break;
            en = (cyc == pulse_at);
        end
        en = 1'b0;
    endtask

    typedef struct {
        logic [7:0] len;
        logic [7:0] ct1;
        logic [7:0] ct2;
        logic [7:0] s1;
        logic [7:0] p_idx;
        logic [7:0] p_val;
        logic [7:0] e1;
        logic [7:0] e2;
        int         ecyc;
        logic [7:0] ca;
        logic [7:0] ea;
        logic [7:0] cb;
        logic [7:0] eb;
    } vec_t;

    vec_t       vecs [5];
    int         cyc;
    int         c0;
    logic [7:0] key [3];
    int         ks [256];
    int         ep [256];
    int         ii, jj, tmp;

    initial begin
        vecs[0] = '{8'd1, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                    8'h02, 8'h00, 12, 8'd1, 8'd1, 8'd2, 8'd2};
        vecs[1] = '{8'd2, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00,
                    8'h02, 8'hFA, 20, 8'd2, 8'd3, 8'd3, 8'd2};
        vecs[2] = '{8'd0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                    8'h00, 8'h00, 4, 8'd1, 8'd1, 8'd0, 8'd0};
        vecs[3] = '{8'd1, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF,
                    8'hFE, 8'h00, 12, 8'd1, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{8'd1, 8'h10, 8'h00, 8'h05, 8'h05, 8'h01,
                    8'h16, 8'h00, 12, 8'd1, 8'd1, 8'd5, 8'd5};

        for (int a = 0; a < 256; a++) begin
            sinit[a] = 8'(a);
            ctmem[a] = 8'h00;
        end

        rst = 1'b1;
        en  = 1'b0;
        load_mem();
        @(negedge clk);
        chk("rst_rdy", int'(rdy), 1);
        chk("rst_swren", int'(s_wren), 0);
        chk("rst_ptwren", int'(pt_wren), 0);
        chk("rst_saddr", int'(s_addr), 0);
        chk("rst_ctaddr", int'(ct_addr), 0);
        chk("rst_ptaddr", int'(pt_addr), 0);
        chk("rst_wrdata", int'(s_wrdata) + int'(pt_wrdata), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int a = 0; a < 256; a++) sinit[a] = 8'(a);
            sinit[1]             = vecs[v].s1;
            sinit[vecs[v].p_idx] = vecs[v].p_val;
            if (vecs[v].p_idx == 8'd0) sinit[0] = 8'd0;
            ctmem[0] = vecs[v].len;
            ctmem[1] = vecs[v].ct1;
            ctmem[2] = vecs[v].ct2;
            load_mem();
            run_job(-1, cyc);
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].ecyc);
            chk($sformatf("v%0d_pt0", v), int'(ptmem[0]),
                int'(vecs[v].len));
            if (vecs[v].len >= 8'd1)
                chk($sformatf("v%0d_pt1", v), int'(ptmem[1]),
                    int'(vecs[v].e1));
            if (vecs[v].len >= 8'd2)
                chk($sformatf("v%0d_pt2", v), int'(ptmem[2]),
                    int'(vecs[v].e2));
            chk($sformatf("v%0d_pt_tail", v),
                int'(ptmem[int'(vecs[v].len) + 1]), 'hEE);
            chk($sformatf("v%0d_sa", v), int'(smem[vecs[v].ca]),
                int'(vecs[v].ea));
            chk($sformatf("v%0d_sb", v), int'(smem[vecs[v].cb]),
                int'(vecs[v].eb));
            chk($sformatf("v%0d_swr", v), s_wr_cnt, 2 * int'(vecs[v].len));
            chk($sformatf("v%0d_ptwr", v), pt_wr_cnt,
                int'(vecs[v].len) + 1);
        end

        // en pulsed while busy must not disturb the run
        for (int a = 0; a < 256; a++) sinit[a] = 8'(a);
        ctmem[0] = 8'd1;
        ctmem[1] = 8'h33;
        load_mem();
        run_job(5, cyc);
        chk("pulse_cycles", cyc, 12);
        chk("pulse_pt1", int'(ptmem[1]), 'h31);
        chk("pulse_ptwr", pt_wr_cnt, 2);
        repeat (3) @(negedge clk);
        chk("pulse_idle", int'(rdy), 1);
        chk("pulse_no_rerun", pt_wr_cnt, 2);

        // reset just before the swap writes
        ctmem[0] = 8'd2;
        ctmem[1] = 8'h00;
        ctmem[2] = 8'hFF;
        load_mem();
        en = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            en = 1'b0;
        end
        chk("mid_busy", int'(rdy), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0 = s_wr_cnt + pt_wr_cnt;
        chk("mid_rst_rdy", int'(rdy), 1);
        chk("mid_rst_swren", int'(s_wren), 0);
        chk("mid_rst_saddr", int'(s_addr), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_nowr", s_wr_cnt + pt_wr_cnt, c0);
        chk("mid_rst_swr", s_wr_cnt, 0);
        chk("mid_rst_idle", int'(rdy), 1);

        // full-length message against a software RC4
        key[0] = 8'h4B;
        key[1] = 8'h65;
        key[2] = 8'h79;
        for (int a = 0; a < 256; a++) ks[a] = a;
        jj = 0;
        for (int a = 0; a < 256; a++) begin
            jj     = (jj + ks[a] + int'(key[a % 3])) % 256;
            tmp    = ks[a];
            ks[a]  = ks[jj];
            ks[jj] = tmp;
        end
        for (int a = 0; a < 256; a++) sinit[a] = 8'(ks[a]);
        ctmem[0] = 8'd255;
        for (int a = 1; a < 256; a++) ctmem[a] = 8'($urandom_range(0, 255));
        ep[0] = 255;
        ii = 0;
        jj = 0;
        for (int a = 1; a < 256; a++) begin
            ii     = (ii + 1) % 256;
            jj     = (jj + ks[ii]) % 256;
            tmp    = ks[ii];
            ks[ii] = ks[jj];
            ks[jj] = tmp;
            ep[a]  = int'(ctmem[a]) ^ ks[(ks[ii] + ks[jj]) % 256];
        end
        load_mem();
        run_job(-1, cyc);
        chk("rand_cycles", cyc, 4 + 8 * 255);
        for (int a = 0; a < 256; a++)
            chk($sformatf("rand_pt%0d", a), int'(ptmem[a]), ep[a]);
        for (int a = 0; a < 256; a++)
            chk($sformatf("rand_s%0d", a), int'(smem[a]), ks[a]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
